ascii_uart_tx: RTL



---
 rtl/ascii_uart_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: 8N1 serial transmitter for 7-bit ASCII characters.
// A character is accepted through a valid/ready handshake while idle. It is sent
// as one start bit, eight data bits LSB first (bit 7 is always 0) and one stop bit.
// Each bit lasts CLKS_PER_BIT clock cycles.
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       tx,
    output logic       busy
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    // State register: synchronous reset has priority over every other event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values of the others.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign bit_end = (cnt_q == CNT_MAX);

    // Next-state logic: handshake, bit-time counting and data shifting.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        unique case (state_q)
            S_IDLE: begin
                if (char_valid) begin
                    sh_d    = {1'b0, char_in};
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the line level is computed from the next state so the
    // registered tx lines up with the state it belongs to, with no extra delay.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign char_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);

endmodule
